puf_response_serializer: RTL and testbench

//  Downstream of the PUF core/FSM stage. Captures each (loop_number, loop_response) pair on

---
 rtl/puf_ser_pkg.sv | 29 ++
 rtl/puf_resp_fifo.sv | 63 ++++++
 rtl/puf_response_serializer.sv | 182 ++++++++++++++++++
 tb/tb_puf_response_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/puf_ser_pkg.sv
// Shared types and constants for the PUF response serializer.
// PUF_SER_CHECKSUM_EN adds the CSUM state (7-byte frames with XOR checksum byte).
package puf_ser_pkg;

    localparam int FRAME_BYTES     = 6;
    localparam int LOOP_FIELD_BITS = 16;
    localparam int FRAME_BITS      = FRAME_BYTES * 8;
    localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
`ifdef PUF_SER_CHECKSUM_EN
        CSUM,
`endif
        TERM
    } ser_state_t;

    function automatic logic [7:0] frame_xor(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            acc = acc ^ frame[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/puf_resp_fifo.sv
// Synchronous FIFO holding {loop_number, loop_response} entries; show-ahead read port.
// A pop never frees space for a push in the same cycle because full is evaluated before the edge.
module puf_resp_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/puf_response_serializer.sv
// Buffers PUF loop results and streams them as big-endian byte frames, then a terminator byte.
// Define PUF_SER_CHECKSUM_EN to append an XOR checksum byte to every frame.
//
// state | meaning
// IDLE  | waiting for a buffered entry or a pending done
// LOAD  | head entry captured in shift register, tx_valid rises next
// SEND  | frame bytes presented MSB first, one per handshake
// CSUM  | checksum byte presented (checksum build only)
// TERM  | terminator byte presented, done_out pulses on accept
module puf_response_serializer
    import puf_ser_pkg::*;
#(
    parameter int         TOT_CNT_BITS  = 32,
    parameter int         LOOP_NUM_BITS = 11,
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [7:0] TERM_BYTE     = TERM_BYTE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     store_resp,
    input  logic [LOOP_NUM_BITS-1:0] loop_number,
    input  logic [TOT_CNT_BITS-1:0]  loop_response,
    input  logic                     puf_done,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done_out
);

    localparam int ENTRY_W = LOOP_NUM_BITS + TOT_CNT_BITS;

    ser_state_t            state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [2:0]            byte_idx;
    logic                  done_pending;
    logic                  puf_done_q;
    logic                  done_rise;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head;
    logic [FRAME_BITS-1:0] next_frame;
    logic                  last_data_xfer;
    logic                  frame_end;
`ifdef PUF_SER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    puf_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (store_resp),
        .wr_data ({loop_number, loop_response}),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign next_frame     = {{(LOOP_FIELD_BITS-LOOP_NUM_BITS){1'b0}}, head};
    assign done_rise      = puf_done && !puf_done_q;
    assign tx_data        = shift_reg[FRAME_BITS-1 -: 8];
    assign busy           = !fifo_empty || (state != IDLE) || done_pending;
    assign last_data_xfer = (state == SEND) && tx_ready && (byte_idx == 3'(FRAME_BYTES-1));
`ifdef PUF_SER_CHECKSUM_EN
    assign frame_end      = (state == CSUM) && tx_ready;
`else
    assign frame_end      = last_data_xfer;
`endif
    // Pop coincides with the edge that moves the FSM into LOAD.
    assign fifo_pop = !clear && !fifo_empty && ((state == IDLE) || frame_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            byte_idx     <= '0;
            tx_valid     <= 1'b0;
            done_out     <= 1'b0;
            done_pending <= 1'b0;
            overflow     <= 1'b0;
            puf_done_q   <= 1'b0;
`ifdef PUF_SER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            puf_done_q <= puf_done;
            done_out   <= 1'b0;
            if (clear) begin
                state        <= IDLE;
                shift_reg    <= '0;
                byte_idx     <= '0;
                tx_valid     <= 1'b0;
                done_pending <= 1'b0;
                overflow     <= 1'b0;
            end else begin
                if (store_resp && fifo_full) begin
                    overflow <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            shift_reg <= next_frame;
`ifdef PUF_SER_CHECKSUM_EN
                            csum      <= frame_xor(next_frame);
`endif
                            byte_idx  <= '0;
                            state     <= LOAD;
                        end else if (done_pending) begin
                            shift_reg <= {TERM_BYTE, {(FRAME_BITS-8){1'b0}}};
                            tx_valid  <= 1'b1;
                            state     <= TERM;
                        end
                    end
                    LOAD: begin
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                    SEND: begin
                        if (last_data_xfer) begin
`ifdef PUF_SER_CHECKSUM_EN
                            shift_reg <= {csum, {(FRAME_BITS-8){1'b0}}};
                            state     <= CSUM;
`else
                            tx_valid <= 1'b0;
                            byte_idx <= '0;
                            if (!fifo_empty) begin
                                shift_reg <= next_frame;
                                state     <= LOAD;
                            end else begin
                                shift_reg <= '0;
                                state     <= IDLE;
                            end
`endif
                        end else if (tx_ready) begin
                            shift_reg <= shift_reg << 8;
                            byte_idx  <= byte_idx + 3'd1;
                        end
                    end
`ifdef PUF_SER_CHECKSUM_EN
                    CSUM: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            byte_idx <= '0;
                            if (!fifo_empty) begin
                                shift_reg <= next_frame;
                                csum      <= frame_xor(next_frame);
                                state     <= LOAD;
                            end else begin
                                shift_reg <= '0;
                                state     <= IDLE;
                            end
                        end
                    end
`endif
                    TERM: begin
                        if (tx_ready) begin
                            tx_valid     <= 1'b0;
                            shift_reg    <= '0;
                            done_out     <= 1'b1;
                            done_pending <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
                // A new run's done edge wins over the terminator clearing the old one.
                if (done_rise) begin
                    done_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_response_serializer.sv
// Directed bench for puf_response_serializer; honours PUF_SER_CHECKSUM_EN for 7-byte frames.
module tb_puf_response_serializer;

`ifdef PUF_SER_CHECKSUM_EN
    localparam int FB = 7;
`else
    localparam int FB = 6;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        store_resp = 1'b0;
    logic [10:0] loop_number = '0;
    logic [31:0] loop_response = '0;
    logic        puf_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        overflow;
    logic        busy;
    logic        done_out;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] got [$];

    puf_response_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .store_resp    (store_resp),
        .loop_number   (loop_number),
        .loop_response (loop_response),
        .puf_done      (puf_done),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .overflow      (overflow),
        .busy          (busy),
        .done_out      (done_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [10:0] ln, input logic [31:0] r, input int k);
        logic [47:0] f;
        f = {5'b00000, ln, r};
        if (k < 6) return f[47-8*k -: 8];
        return f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
    endfunction

    // mode 0: ready every cycle; mode 1: ready one cycle in three
    task automatic collect(input int n, input int mode);
        int c;
        logic stall;
        logic [7:0] pd;
        c = 0;
        stall = 1'b0;
        pd = '0;
        got.delete();
        while (got.size() < n && c < 3000) begin
            @(negedge clk);
            if (stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(pd));
            end
            tx_ready = (mode == 0) ? 1'b1 : (c % 3 == 2);
            if (tx_valid && tx_ready) got.push_back(tx_data);
            stall = tx_valid && !tx_ready;
            pd = tx_data;
            c++;
        end
        chk("collect_count", 32'(got.size()), 32'(n));
    endtask

    task automatic push_one(input logic [10:0] ln, input logic [31:0] r);
        @(negedge clk);
        store_resp    = 1'b1;
        loop_number   = ln;
        loop_response = r;
        @(negedge clk);
        store_resp = 1'b0;
    endtask

    initial begin
        int n;
        int vcnt;
        logic [7:0] t1 [6];
        t1 = '{8'h01, 8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        #12;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done_out", 32'(done_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: single entry, latency and byte order
        @(negedge clk);
        store_resp = 1'b1; loop_number = 11'h123; loop_response = 32'hDEADBEEF;
        n = 0;
        while (n < 10 && !tx_valid) begin
            @(posedge clk); #1;
            n++;
            store_resp = 1'b0;
        end
        chk("first_valid_latency", 32'(n), 32'd3);
        collect(FB, 0);
        for (int i = 0; i < 6; i++) chk("t1_byte", 32'(got[i]), 32'(t1[i]));
        if (FB == 7) chk("t1_csum", 32'(got[6]), 32'(exp_byte(11'h123, 32'hDEADBEEF, 6)));
        @(negedge clk);
        tx_ready = 1'b0;
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: back-pressure 1-of-3
        push_one(11'h123, 32'hDEADBEEF);
        collect(FB, 1);
        for (int i = 0; i < FB; i++) chk("t2_byte", 32'(got[i]), 32'(exp_byte(11'h123, 32'hDEADBEEF, i)));
        @(negedge clk);
        tx_ready = 1'b0;

        // 3: fill past capacity; first entry already sits in the shift register
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 17) chk("t3_no_ovf_at_full", 32'(overflow), 32'd0);
            store_resp    = 1'b1;
            loop_number   = 11'(i * 11'h51);
            loop_response = 32'hA5000000 | (32'(i) * 32'h00010203);
        end
        @(negedge clk);
        store_resp = 1'b0;
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_busy", 32'(busy), 32'd1);
        collect(17 * FB, 0);
        for (int e = 0; e < 17; e++)
            for (int k = 0; k < FB; k++)
                chk("t3_byte", 32'(got[e*FB+k]),
                    32'(exp_byte(11'(e * 11'h51), 32'hA5000000 | (32'(e) * 32'h00010203), k)));
        @(negedge clk);
        tx_ready = 1'b0;
        chk("t3_drained", 32'(busy), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // clear beats a simultaneous push and drops overflow
        @(negedge clk);
        clear = 1'b1; store_resp = 1'b1; loop_number = 11'h3; loop_response = 32'h3;
        @(negedge clk);
        clear = 1'b0; store_resp = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("clr_no_valid", 32'(tx_valid), 32'd0);

        // 4: two entries, done with the second push, terminator last
        @(negedge clk);
        store_resp = 1'b1; loop_number = 11'h7FF; loop_response = 32'h12345678;
        @(negedge clk);
        loop_number = 11'h000; loop_response = 32'hFFFFFFFF; puf_done = 1'b1;
        @(negedge clk);
        store_resp = 1'b0; puf_done = 1'b0;
        collect(2 * FB + 1, 0);
        for (int k = 0; k < FB; k++) chk("t4_e0", 32'(got[k]), 32'(exp_byte(11'h7FF, 32'h12345678, k)));
        for (int k = 0; k < FB; k++) chk("t4_e1", 32'(got[FB+k]), 32'(exp_byte(11'h000, 32'hFFFFFFFF, k)));
        chk("t4_term", 32'(got[2*FB]), 32'h5A);
        @(negedge clk);
        tx_ready = 1'b0;
        chk("t4_done_pulse", 32'(done_out), 32'd1);
        chk("t4_busy_after", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_done_width", 32'(done_out), 32'd0);

        // 5: async reset after third byte
        push_one(11'h2AA, 32'hCAFEF00D);
        collect(3, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("t5_valid", 32'(tx_valid), 32'd0);
        chk("t5_data", 32'(tx_data), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            if (tx_valid) vcnt++;
        end
        chk("t5_no_stale", 32'(vcnt), 32'd0);
        tx_ready = 1'b0;

`ifdef PUF_SER_CHECKSUM_EN
        // 6: checksum byte
        push_one(11'h005, 32'h00000001);
        collect(7, 0);
        for (int k = 0; k < 6; k++) chk("t6_byte", 32'(got[k]), (k == 1 || k == 5) ? ((k == 1) ? 32'h05 : 32'h01) : 32'h00);
        chk("t6_csum", 32'(got[6]), 32'h04);
        @(negedge clk);
        tx_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
